// File: rtl/dcache_if.sv
// dcache_if: core load/store port and 128-bit memory block port of the data cache
interface dcache_if;
    logic         cpu_req;
    logic         cpu_we;
    logic [1:0]   cpu_type;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_din;
    logic         cpu_sign_ext;
    logic [31:0]  cpu_dout;
    logic         cpu_stall;
    logic         mem_block_read;
    logic         mem_block_write;
    logic [31:0]  mem_block_addr;
    logic [127:0] mem_block_wdata;
    logic [127:0] mem_block_rdata;
    logic         mem_block_ready;
    modport slave (
        input  cpu_req, cpu_we, cpu_type, cpu_addr, cpu_din, cpu_sign_ext, mem_block_rdata, mem_block_ready,
        output cpu_dout, cpu_stall, mem_block_read, mem_block_write, mem_block_addr, mem_block_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_type, cpu_addr, cpu_din, cpu_sign_ext, mem_block_rdata, mem_block_ready,
        input  cpu_dout, cpu_stall, mem_block_read, mem_block_write, mem_block_addr, mem_block_wdata
    );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with 16-byte lines
module dcache #(
    parameter int NUM_SETS = 64
) (
    input logic     clk,
    input logic     rst,
    dcache_if.slave bus
);
    localparam int IDX = $clog2(NUM_SETS);
    localparam int TW = 28 - IDX;
    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
    state_t state, state_next;
    logic [NUM_SETS-1:0] valid, dirty;
    logic [TW-1:0] tags [NUM_SETS];
    logic [127:0] lines [NUM_SETS];
    logic [IDX-1:0] idx;
    logic [TW-1:0] tag;
    logic [3:0] off;
    logic [127:0] line, rep, merged;
    logic [15:0] be, h;
    logic [7:0] b;
    logic [31:0] w;
    logic hit, store_hit, refill_done;
    assign idx = bus.cpu_addr[4+IDX-1:4];
    assign tag = bus.cpu_addr[31:4+IDX];
    assign off = bus.cpu_addr[3:0];
    assign line = lines[idx];
    assign hit = bus.cpu_req && valid[idx] && tags[idx] == tag && state == IDLE;
    assign store_hit = hit && bus.cpu_we && bus.cpu_type != 2'b11;
    assign refill_done = state == REFILL && bus.mem_block_ready;
    assign b = line[{off, 3'b0} +: 8];
    assign h = line[{off[3:1], 4'b0} +: 16];
    assign w = line[{off[3:2], 5'b0} +: 32];
    assign bus.cpu_dout = !hit ? 32'h0 :
                          bus.cpu_type == 2'b00 ? {{24{bus.cpu_sign_ext & b[7]}}, b} :
                          bus.cpu_type == 2'b01 ? {{16{bus.cpu_sign_ext & h[15]}}, h} :
                          bus.cpu_type == 2'b10 ? w : 32'h0;
    assign bus.cpu_stall = bus.cpu_req && !hit;
    assign be = bus.cpu_type == 2'b00 ? 16'h0001 << off :
                bus.cpu_type == 2'b01 ? 16'h0003 << {off[3:1], 1'b0} :
                bus.cpu_type == 2'b10 ? 16'h000F << {off[3:2], 2'b0} : 16'h0;
    assign rep = bus.cpu_type == 2'b00 ? {16{bus.cpu_din[7:0]}} :
                 bus.cpu_type == 2'b01 ? {8{bus.cpu_din[15:0]}} : {4{bus.cpu_din}};
    // Requests are dropped in the ready cycle so the memory never sees a fresh one.
    assign bus.mem_block_write = state == WRITEBACK && !bus.mem_block_ready;
    assign bus.mem_block_read = state == REFILL && !bus.mem_block_ready;
    assign bus.mem_block_addr = state == WRITEBACK ? {tags[idx], idx, 4'h0} :
                                state == REFILL ? {tag, idx, 4'h0} : 32'h0;
    assign bus.mem_block_wdata = state == WRITEBACK ? line : 128'h0;
    // Merge the addressed store bytes into the current line.
    always_comb begin
        merged = line;
        for (int k = 0; k < 16; k++)
            merged[8*k +: 8] = be[k] ? rep[8*k +: 8] : line[8*k +: 8];
    end
    // Miss handling: optional dirty write-back, then refill, then retry in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.cpu_req && !hit) state_next = valid[idx] && dirty[idx] ? WRITEBACK : REFILL;
            WRITEBACK: if (bus.mem_block_ready) state_next = REFILL;
            REFILL:    if (bus.mem_block_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end
    // State and per-set status bits; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= state_next;
            if (refill_done) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty[idx] <= 1'b1;
            end
        end
    end
    // Tag and data arrays: refill installs a line, a store hit merges bytes.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tags[idx] <= tag;
            lines[idx] <= bus.mem_block_rdata;
        end else if (store_hit) begin
            lines[idx] <= merged;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed, table-driven checks of dcache against a latency-1 block memory
module tb_dcache;
    localparam int L = 1;
    typedef struct {
        logic        we;
        logic [1:0]  ty;
        logic [31:0] addr;
        logic [31:0] din;
        logic        se;
        logic [31:0] dout;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [127:0] mem [1024];
    dcache_if bus();
    dcache #(.NUM_SETS(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // Block memory: accepts a request while idle, pulses ready L+1 cycles later.
    initial begin
        logic busy;
        int cnt;
        logic [31:0] a;
        busy = 1'b0;
        cnt = 0;
        a = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 128'h0;
        mem[10'h000] = 128'h00000000_00000000_80007F80_DEADBEEF;
        mem[10'h040] = 128'h11111111_22222222_33333333_0BADF00D;
        mem[10'h080] = 128'h44444444_55555555_66666666_600DCAFE;
        bus.mem_block_ready <= 1'b0;
        bus.mem_block_rdata <= 128'h0;
        forever begin
            @(posedge clk);
            bus.mem_block_ready <= 1'b0;
            if (busy) begin
                if (cnt == 1) begin
                    busy = 1'b0;
                    bus.mem_block_ready <= 1'b1;
                    bus.mem_block_rdata <= mem[a[13:4]];
                end else begin
                    cnt--;
                end
            end else if (!bus.mem_block_ready && (bus.mem_block_read || bus.mem_block_write)) begin
                busy = 1'b1;
                cnt = L;
                a = bus.mem_block_addr;
                if (bus.mem_block_write) mem[a[13:4]] = bus.mem_block_wdata;
            end
        end
    end
    // Protocol monitor: never read and write together, never a request alongside ready.
    always @(negedge clk) begin
        checks++;
        if ((bus.mem_block_read && bus.mem_block_write) ||
            (bus.mem_block_ready && (bus.mem_block_read || bus.mem_block_write))) begin
            errors++;
            $display("FAIL protocol: read=%b write=%b ready=%b, required no overlap", bus.mem_block_read,
                     bus.mem_block_write, bus.mem_block_ready);
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic req, input logic we, input logic [1:0] ty, input logic [31:0] addr,
                         input logic [31:0] din, input logic se);
        @(posedge clk);
        #1;
        bus.cpu_req = req;
        bus.cpu_we = we;
        bus.cpu_type = ty;
        bus.cpu_addr = addr;
        bus.cpu_din = din;
        bus.cpu_sign_ext = se;
    endtask
    task automatic mem_idle(input string name);
        chk({name, " rd/wr"}, {bus.mem_block_read, bus.mem_block_write}, 2'b00);
        chk({name, " addr"}, bus.mem_block_addr, 32'h0);
        chk({name, " wdata"}, bus.mem_block_wdata, 128'h0);
    endtask
    // Word load that misses; checks every cycle of the optional write-back and the refill.
    task automatic load_miss(input string name, input logic [31:0] a, input logic wb, input logic [31:0] va,
                             input logic [127:0] vline, input logic [31:0] exp);
        drive(1'b1, 1'b0, 2'b10, a, 32'h0, 1'b0);
        @(negedge clk);
        chk({name, " c0 stall"}, bus.cpu_stall, 1'b1);
        chk({name, " c0 dout"}, bus.cpu_dout, 32'h0);
        chk({name, " c0 req"}, {bus.mem_block_read, bus.mem_block_write}, 2'b00);
        if (wb) begin
            for (int c = 1; c <= L + 1; c++) begin
                @(negedge clk);
                chk({name, " wb rd/wr"}, {bus.mem_block_read, bus.mem_block_write}, 2'b01);
                chk({name, " wb addr"}, bus.mem_block_addr, va);
                chk({name, " wb data"}, bus.mem_block_wdata, vline);
                chk({name, " wb stall"}, bus.cpu_stall, 1'b1);
            end
            @(negedge clk);
            chk({name, " wb done"}, {bus.mem_block_read, bus.mem_block_write, bus.mem_block_ready}, 3'b001);
        end
        for (int c = 1; c <= L + 1; c++) begin
            @(negedge clk);
            chk({name, " rf rd/wr"}, {bus.mem_block_read, bus.mem_block_write}, 2'b10);
            chk({name, " rf addr"}, bus.mem_block_addr, {a[31:4], 4'h0});
            chk({name, " rf stall"}, bus.cpu_stall, 1'b1);
        end
        @(negedge clk);
        chk({name, " rf done"}, {bus.mem_block_read, bus.mem_block_write, bus.mem_block_ready}, 3'b001);
        chk({name, " rf done stall"}, bus.cpu_stall, 1'b1);
        @(negedge clk);
        chk({name, " hit stall"}, bus.cpu_stall, 1'b0);
        chk({name, " hit dout"}, bus.cpu_dout, exp);
        drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
    endtask
    initial begin
        vec_t vt [20];
        vt[0]  = '{1'b0, 2'b00, 32'h00010003, 32'h0, 1'b1, 32'hFFFFFFDE};
        vt[1]  = '{1'b0, 2'b00, 32'h00010003, 32'h0, 1'b0, 32'h000000DE};
        vt[2]  = '{1'b0, 2'b01, 32'h00010000, 32'h0, 1'b1, 32'hFFFFBEEF};
        vt[3]  = '{1'b0, 2'b01, 32'h00010002, 32'h0, 1'b0, 32'h0000DEAD};
        vt[4]  = '{1'b0, 2'b01, 32'h00010003, 32'h0, 1'b1, 32'hFFFFDEAD};
        vt[5]  = '{1'b0, 2'b10, 32'h00010004, 32'h0, 1'b0, 32'h80007F80};
        vt[6]  = '{1'b0, 2'b00, 32'h00010004, 32'h0, 1'b1, 32'hFFFFFF80};
        vt[7]  = '{1'b0, 2'b01, 32'h00010006, 32'h0, 1'b1, 32'hFFFF8000};
        vt[8]  = '{1'b0, 2'b00, 32'h00010005, 32'h0, 1'b1, 32'h0000007F};
        vt[9]  = '{1'b0, 2'b11, 32'h00010000, 32'h0, 1'b1, 32'h00000000};
        vt[10] = '{1'b0, 2'b10, 32'h00010007, 32'h0, 1'b0, 32'h80007F80};
        vt[11] = '{1'b1, 2'b00, 32'h00010001, 32'hAAAAAA55, 1'b0, 32'h0};
        vt[12] = '{1'b0, 2'b10, 32'h00010000, 32'h0, 1'b0, 32'hDEAD55EF};
        vt[13] = '{1'b1, 2'b11, 32'h00010000, 32'h0, 1'b0, 32'h0};
        vt[14] = '{1'b0, 2'b10, 32'h00010000, 32'h0, 1'b0, 32'hDEAD55EF};
        vt[15] = '{1'b1, 2'b01, 32'h0001000B, 32'h77771234, 1'b0, 32'h0};
        vt[16] = '{1'b0, 2'b10, 32'h00010008, 32'h0, 1'b0, 32'h12340000};
        vt[17] = '{1'b1, 2'b10, 32'h0001000E, 32'hCAFEF00D, 1'b0, 32'h0};
        vt[18] = '{1'b0, 2'b10, 32'h0001000C, 32'h0, 1'b0, 32'hCAFEF00D};
        vt[19] = '{1'b0, 2'b00, 32'h0001000F, 32'h0, 1'b0, 32'h000000CA};
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_type = 2'b10;
        bus.cpu_addr = 32'h00010000;
        bus.cpu_din = 32'h0;
        bus.cpu_sign_ext = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        mem_idle("reset");
        chk("reset stall", bus.cpu_stall, 1'b1);
        chk("reset dout", bus.cpu_dout, 32'h0);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("reset idle stall", bus.cpu_stall, 1'b0);
        rst = 1'b1;
        load_miss("cold", 32'h00010000, 1'b0, 32'h0, 128'h0, 32'hDEADBEEF);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, vt[i].we, vt[i].ty, vt[i].addr, vt[i].din, vt[i].se);
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), bus.cpu_stall, 1'b0);
            chk($sformatf("vec%0d memreq", i), {bus.mem_block_read, bus.mem_block_write}, 2'b00);
            if (!vt[i].we) chk($sformatf("vec%0d dout", i), bus.cpu_dout, vt[i].dout);
        end
        drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        mem_idle("after stores");
        load_miss("dirty", 32'h00010400, 1'b1, 32'h00010000,
                  128'hCAFEF00D_12340000_80007F80_DEAD55EF, 32'h0BADF00D);
        load_miss("reload", 32'h00010000, 1'b0, 32'h0, 128'h0, 32'hDEAD55EF);
        drive(1'b1, 1'b0, 2'b10, 32'h0001000C, 32'h0, 1'b0);
        @(negedge clk);
        chk("reload word3", bus.cpu_dout, 32'hCAFEF00D);
        load_miss("clean", 32'h00010800, 1'b0, 32'h0, 128'h0, 32'h600DCAFE);
        load_miss("back", 32'h00010000, 1'b0, 32'h0, 128'h0, 32'hDEAD55EF);
        drive(1'b1, 1'b0, 2'b10, 32'h00010400, 32'h0, 1'b0);
        @(negedge clk);
        chk("rstrf c0 stall", bus.cpu_stall, 1'b1);
        @(negedge clk);
        chk("rstrf c1 read", bus.mem_block_read, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        mem_idle("rstrf drop");
        chk("rstrf drop stall", bus.cpu_stall, 1'b1);
        chk("rstrf drop dout", bus.cpu_dout, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_idle($sformatf("rstrf hold%0d", c));
        end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        load_miss("post-reset", 32'h00010000, 1'b0, 32'h0, 128'h0, 32'hDEAD55EF);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
